// File: rtl/aes_round_sched.sv
// AES-128 round scheduler: sequences ARK / SUB / SHIFT / MIX through shared step units.
// Optional WAIT timeout with sticky err: define AES_SCHED_TIMEOUT_EN.
module aes_round_sched #(
    parameter int NR      = 10,
    parameter int TMO_CYC = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [127:0] din,
    output logic         busy,
    output logic         done,
    output logic [127:0] dout,
    output logic [3:0]   round_idx,
    input  logic [127:0] round_key,
    output logic [1:0]   step_sel,
    output logic         step_ena,
    output logic [127:0] step_in,
    input  logic [127:0] step_out,
    input  logic         step_done,
    output logic         err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    localparam logic [1:0] SEL_SUB   = 2'd0;
    localparam logic [1:0] SEL_SHIFT = 2'd1;
    localparam logic [1:0] SEL_MIX   = 2'd2;
    localparam logic [1:0] SEL_ARK   = 2'd3;
    localparam logic [3:0] LAST_RND  = 4'(NR);
    localparam logic [3:0] TMO_LAST  = 4'(TMO_CYC - 1);

    state_t         state_r, state_next_s;
    logic [127:0]   wreg_r, wreg_next_s;
    logic [127:0]   dout_r, dout_next_s;
    logic [1:0]     sel_r, sel_next_s;
    logic [3:0]     idx_r, idx_next_s;
    logic           busy_r, done_r, ena_r;
    logic           tmo_hit_s;
    logic           unused_s;

    // The final round has no MixColumns; every ARK closes a round.
    function automatic logic [1:0] next_sel(input logic [1:0] sel, input logic last_rnd);
        case (sel)
            SEL_SUB:   next_sel = SEL_SHIFT;
            SEL_SHIFT: next_sel = last_rnd ? SEL_ARK : SEL_MIX;
            SEL_MIX:   next_sel = SEL_ARK;
            default:   next_sel = SEL_SUB;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and next working-state selection
    always_comb begin
        state_next_s = state_r;
        wreg_next_s  = wreg_r;
        dout_next_s  = dout_r;
        sel_next_s   = sel_r;
        idx_next_s   = idx_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_next_s = S_ISSUE;
                    wreg_next_s  = din;
                    sel_next_s   = SEL_ARK;
                    idx_next_s   = 4'd0;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    state_next_s = S_IDLE;
                    idx_next_s   = 4'd0;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort || tmo_hit_s) begin
                    state_next_s = S_IDLE;
                    idx_next_s   = 4'd0;
                end else if (step_done) begin
                    wreg_next_s = step_out;
                    if (sel_r == SEL_ARK && idx_r == LAST_RND) begin
                        state_next_s = S_FIN;
                        dout_next_s  = step_out;
                        idx_next_s   = 4'd0;
                    end else begin
                        state_next_s = S_ISSUE;
                        sel_next_s   = next_sel(sel_r, idx_r == LAST_RND);
                        idx_next_s   = (sel_r == SEL_ARK) ? idx_r + 4'd1 : idx_r;
                    end
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_FIN: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs, all derived from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wreg_r <= 128'd0;
            dout_r <= 128'd0;
            sel_r  <= 2'd0;
            idx_r  <= 4'd0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            ena_r  <= 1'b0;
        end else begin
            wreg_r <= wreg_next_s;
            dout_r <= dout_next_s;
            sel_r  <= sel_next_s;
            idx_r  <= idx_next_s;
            busy_r <= (state_next_s == S_ISSUE) || (state_next_s == S_WAIT);
            done_r <= (state_next_s == S_FIN);
            ena_r  <= (state_next_s == S_ISSUE);
        end
    end

`ifdef AES_SCHED_TIMEOUT_EN
    logic [3:0] tmo_r;
    logic       err_r;

    assign tmo_hit_s = (state_r == S_WAIT) && !step_done && !abort && (tmo_r == TMO_LAST);

    // WAIT-cycle counter per step; err holds until the next accepted start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_r <= 4'd0;
            err_r <= 1'b0;
        end else begin
            if (state_r == S_ISSUE) begin
                tmo_r <= 4'd0;
            end else if (state_r == S_WAIT) begin
                tmo_r <= tmo_r + 4'd1;
            end else begin
                tmo_r <= tmo_r;
            end
            if (state_r == S_IDLE && start) begin
                err_r <= 1'b0;
            end else if (tmo_hit_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign err = err_r;
`else
    assign tmo_hit_s = 1'b0;
    assign err       = 1'b0;
`endif

    // round_key is consumed by the external ARK unit, not by the scheduler
    assign unused_s = ^round_key ^ (TMO_CYC > 0);

    assign busy      = busy_r;
    assign done      = done_r;
    assign dout      = dout_r;
    assign round_idx = idx_r;
    assign step_sel  = sel_r;
    assign step_ena  = ena_r;
    assign step_in   = wreg_r;

endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: behavioural AES step units with one-cycle latency,
// key schedule from key 000102..0f, and a queue scoreboard of expected ciphertexts.
module tb_aes_round_sched;

    logic         clk = 1'b0;
    logic         rst, start, abort;
    logic [127:0] din, dout, round_key, step_in, step_out;
    logic         busy, done, step_ena, step_done, err;
    logic [3:0]   round_idx;
    logic [1:0]   step_sel;

    logic         unit_done = 1'b0;
    logic         inj_done, hang;
    logic [7:0]   sbox [256];
    logic [127:0] rk [16];
    logic [127:0] exp_q [$];
    logic [1:0]   sel_log [$];
    logic [3:0]   idx_log [$];
    int           n_vec = 0, n_err = 0;
    int           cyc = 0, done_cnt = 0, done_cyc = 0, mix_last_viol = 0, start_cyc = 0;
    logic [127:0] last_ct;

    localparam logic [127:0] KEY     = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] FIPS_PT = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] FIPS_CT = 128'h5ac5b47080b7cdd830047b6ad8e0c469;

    aes_round_sched dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .din(din),
        .busy(busy), .done(done), .dout(dout), .round_idx(round_idx),
        .round_key(round_key), .step_sel(step_sel), .step_ena(step_ena),
        .step_in(step_in), .step_out(step_out), .step_done(step_done), .err(err)
    );

    always #5 clk = ~clk;

    assign round_key = rk[round_idx];
    assign step_done = unit_done | inj_done;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        gmul = p;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        for (int i = 0; i < 16; i++) sub_bytes[8*i +: 8] = sbox[s[8*i +: 8]];
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                shift_rows[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8];      a1 = s[32*c+8 +: 8];
            a2 = s[32*c+16 +: 8];   a3 = s[32*c+24 +: 8];
            mix_columns[32*c +: 8]    = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
            mix_columns[32*c+8 +: 8]  = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
            mix_columns[32*c+16 +: 8] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
            mix_columns[32*c+24 +: 8] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
        end
    endfunction

    function automatic logic [127:0] unit_f(input logic [1:0] sel, input logic [127:0] s,
                                            input logic [127:0] k);
        case (sel)
            2'd0:    unit_f = sub_bytes(s);
            2'd1:    unit_f = shift_rows(s);
            2'd2:    unit_f = mix_columns(s);
            default: unit_f = s ^ k;
        endcase
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt);
        logic [127:0] s = pt ^ rk[0];
        for (int r = 1; r < 10; r++) s = mix_columns(shift_rows(sub_bytes(s))) ^ rk[r];
        aes_ref = shift_rows(sub_bytes(s)) ^ rk[10];
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Step units: result and done one cycle after ena (done withheld when hang is set)
    always @(posedge clk) begin
        unit_done <= step_ena && !hang;
        step_out  <= unit_f(step_sel, step_in, round_key);
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: step sequence log and scoreboard pop on done
    always @(negedge clk) begin
        if (rst && step_ena) begin
            sel_log.push_back(step_sel);
            idx_log.push_back(round_idx);
            if (step_sel == 2'd2 && round_idx == 4'd10) mix_last_viol <= mix_last_viol + 1;
        end
        if (rst && done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            check_eq("busy_with_done", 128'(busy), 128'd0);
            if (exp_q.size() > 0) check_eq("dout", dout, exp_q.pop_front());
            else check_eq("done_unexpected", 128'(done), 128'd0);
        end
    end

    task automatic step_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [127:0] d, input bit push, input logic [127:0] e);
        din   = d;
        start = 1'b1;
        if (push) exp_q.push_back(e);
        start_cyc = cyc;
        sel_log.delete();
        idx_log.delete();
        step_cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0, input string tag);
        int k = 0;
        while (done_cnt == n0 && k < 400) begin
            step_cyc();
            k++;
        end
        check_eq(tag, 128'(done_cnt - n0), 128'd1);
    endtask

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_busy"}, 128'(busy), 128'd0);
        check_eq({pfx, "_done"}, 128'(done), 128'd0);
        check_eq({pfx, "_dout"}, dout, 128'd0);
        check_eq({pfx, "_ena"}, 128'(step_ena), 128'd0);
        check_eq({pfx, "_sel"}, 128'(step_sel), 128'd0);
        check_eq({pfx, "_idx"}, 128'(round_idx), 128'd0);
        check_eq({pfx, "_err"}, 128'(err), 128'd0);
        check_eq({pfx, "_state"}, step_in, 128'd0);
    endtask

    initial begin
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rcon, inv, c63, y;
        logic [1:0]   exp_sel [$];
        logic [3:0]   exp_idx [$];
        logic [127:0] e;
        int           n0;

        rst = 1'b0; start = 1'b0; abort = 1'b0; din = 128'd0;
        hang = 1'b0; inj_done = 1'b0;

        c63 = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int v = 1; v < 256; v++) if (gmul(8'(x), 8'(v)) == 8'h01) inv = 8'(v);
            for (int i = 0; i < 8; i++)
                y[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
            sbox[x] = y;
        end
        for (int i = 0; i < 4; i++) w[i] = KEY[32*i +: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[7:0], t[31:8]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {24'd0, rcon};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk[r] = (r < 11) ? {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]} : 128'd0;

        exp_sel.push_back(2'd3); exp_idx.push_back(4'd0);
        for (int r = 1; r < 10; r++)
            for (int s = 0; s < 4; s++) begin
                exp_sel.push_back(2'(s)); exp_idx.push_back(4'(r));
            end
        exp_sel.push_back(2'd0); exp_sel.push_back(2'd1); exp_sel.push_back(2'd3);
        repeat (3) exp_idx.push_back(4'd10);

        repeat (3) step_cyc();
        check_reset_vals("por");
        rst = 1'b1;
        step_cyc();

        // FIPS-197 known answer, cycle timing and step sequence
        n0 = done_cnt;
        do_start(FIPS_PT, 1'b1, FIPS_CT);
        check_eq("busy_after_start", 128'(busy), 128'd1);
        wait_done(n0, "fips_done");
        check_eq("done_cycle", 128'(done_cyc - start_cyc), 128'd81);
        check_eq("done_pulse", 128'(done), 128'd0);
        check_eq("seq_len", 128'(sel_log.size()), 128'd40);
        for (int i = 0; i < 40 && i < sel_log.size(); i++) begin
            check_eq($sformatf("seq_sel%0d", i), 128'(sel_log[i]), 128'(exp_sel[i]));
            check_eq($sformatf("seq_idx%0d", i), 128'(idx_log[i]), 128'(exp_idx[i]));
        end
        last_ct = FIPS_CT;

        // start pulses while busy are ignored; dout held afterwards
        n0 = done_cnt;
        e = aes_ref(128'h0123456789abcdeffedcba9876543210);
        do_start(128'h0123456789abcdeffedcba9876543210, 1'b1, e);
        for (int i = 0; i < 30; i++) begin
            din   = 128'hdeadbeef_00000000_cafef00d_00000000 ^ 128'(i);
            start = i[0];
            step_cyc();
        end
        start = 1'b0;
        wait_done(n0, "busy_start_done");
        repeat (5) step_cyc();
        check_eq("dout_hold", dout, e);
        check_eq("one_done", 128'(done_cnt - n0), 128'd1);
        last_ct = e;

        // abort in the WAIT of step 20, late done ignored, then a normal run
        n0 = done_cnt;
        do_start(128'h00000000ffffffff00000000ffffffff, 1'b0, 128'd0);
        repeat (41) step_cyc();
        check_eq("w20_busy", 128'(busy), 128'd1);
        check_eq("w20_ena", 128'(step_ena), 128'd0);
        check_eq("w20_sel", 128'(step_sel), 128'd3);
        check_eq("w20_idx", 128'(round_idx), 128'd5);
        abort = 1'b1;
        step_cyc();
        abort = 1'b0;
        check_eq("abort_busy", 128'(busy), 128'd0);
        check_eq("abort_done", 128'(done), 128'd0);
        check_eq("abort_ena", 128'(step_ena), 128'd0);
        check_eq("abort_dout", dout, last_ct);
        step_cyc();
        inj_done = 1'b1;
        step_cyc();
        inj_done = 1'b0;
        check_eq("late_done_busy", 128'(busy), 128'd0);
        check_eq("late_done_ena", 128'(step_ena), 128'd0);
        repeat (3) step_cyc();
        check_eq("no_done_abort", 128'(done_cnt - n0), 128'd0);
        check_eq("abort_dout_kept", dout, last_ct);
        e = aes_ref(128'h11111111222222223333333344444444);
        do_start(128'h11111111222222223333333344444444, 1'b1, e);
        wait_done(n0, "after_abort_done");
        last_ct = e;

        // asynchronous reset in the middle of an ISSUE cycle
        do_start(128'h55555555aaaaaaaa55555555aaaaaaaa, 1'b0, 128'd0);
        repeat (4) step_cyc();
        #2;
        check_eq("pre_rst_ena", 128'(step_ena), 128'd1);
        rst = 1'b0;
        #1;
        check_reset_vals("arst");
        step_cyc();
        rst = 1'b1;
        step_cyc();
        n0 = done_cnt;
        e = aes_ref(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);
        do_start(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 1'b1, e);
        wait_done(n0, "fresh_done");
        check_eq("fresh_cycle", 128'(done_cyc - start_cyc), 128'd81);
        last_ct = e;

        // unit that never answers
        n0 = done_cnt;
        hang = 1'b1;
        do_start(128'h77777777777777777777777777777777, 1'b0, 128'd0);
`ifdef AES_SCHED_TIMEOUT_EN
        repeat (15) step_cyc();
        check_eq("tmo_pre_err", 128'(err), 128'd0);
        check_eq("tmo_pre_busy", 128'(busy), 128'd1);
        step_cyc();
        check_eq("tmo_err", 128'(err), 128'd1);
        check_eq("tmo_busy", 128'(busy), 128'd0);
        repeat (4) step_cyc();
        check_eq("tmo_err_sticky", 128'(err), 128'd1);
        check_eq("tmo_no_done", 128'(done_cnt - n0), 128'd0);
        hang = 1'b0;
        e = aes_ref(128'h89abcdef0123456789abcdef01234567);
        do_start(128'h89abcdef0123456789abcdef01234567, 1'b1, e);
        check_eq("tmo_err_clear", 128'(err), 128'd0);
        wait_done(n0, "tmo_recover_done");
`else
        repeat (20) step_cyc();
        check_eq("hang_busy", 128'(busy), 128'd1);
        check_eq("hang_err", 128'(err), 128'd0);
        abort = 1'b1;
        step_cyc();
        abort = 1'b0;
        hang = 1'b0;
        check_eq("hang_abort_busy", 128'(busy), 128'd0);
        check_eq("hang_no_done", 128'(done_cnt - n0), 128'd0);
`endif

        repeat (3) step_cyc();
        check_eq("mix_in_last_round", 128'(mix_last_viol), 128'd0);
        check_eq("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_round_sched.md
Name: aes_round_sched

Overview:
Scheduler that sequences one AES-128 encryption through the shared step units (subbytes, shiftrows, mixcolumns, addroundkey).
- Holds the working state register and drives one shared step bus.
- Issues an ena pulse to the selected unit and waits for that unit's done before moving on.
- Sits between the top-level core interface and the step datapath; the key schedule supplies round_key from round_idx.

Parameters:
NR, 10, number of rounds (10 for AES-128); round_idx width fixed at 4 bits.
TMO_CYC, 15, max cycles WAIT may last before a timeout (used only with the optional feature).

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  asynchronous, active-low reset (rst=0 resets immediately)
start  input  1  begin encryption; sampled only in IDLE
abort  input  1  cancel the operation in progress
din  input  128  plaintext; byte0 at [7:0], column c at [32c+31:32c]
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse; dout valid
dout  output  128  ciphertext; held until the next accepted start
round_idx  output  4  round-key index requested from the key schedule (0..NR)
round_key  input  128  round key for round_idx, combinational from the key schedule
step_sel  output  2  0=subbytes 1=shiftrows 2=mixcolumns 3=addroundkey
step_ena  output  1  one-cycle start pulse to the unit selected by step_sel
step_in  output  128  working state; stable from ISSUE through WAIT
step_out  input  128  result of the selected unit
step_done  input  1  done of the selected unit (muxed externally)
err  output  1  timeout flag (TMO_EN only; tied 0 otherwise)

Behaviour:
- Reset (rst=0, async): FSM=IDLE, busy=0, done=0, dout=0, step_ena=0, step_sel=0, round_idx=0, state reg=0, err=0.
- FSM states:
  - IDLE: on start=1, latch din into the state reg, set round_idx=0, step_sel=3, go to ISSUE, busy=1 next cycle. Otherwise start is ignored.
  - ISSUE: step_ena=1 for exactly this cycle, then go to WAIT.
  - WAIT: step_ena=0. When step_done=1, latch step_out into the state reg and select the next step, then go to ISSUE, or to FIN after the final step. step_done seen in any other state is ignored.
  - FIN: dout<=state reg, done=1 for one cycle, busy=0, round_idx=0, go to IDLE.
- Step order:
  - round 0: ARK.
  - rounds 1..NR-1: SUB, SHIFT, MIX, ARK.
  - round NR: SUB, SHIFT, ARK (MIX skipped).
  - round_idx increments when the ARK of the current round completes; 40 steps total for NR=10.
- step_in = state reg at all times. The reg changes only on a WAIT latch, so unit inputs stay stable while a unit is processing, as the multi-cycle step units require.
- Timing, with units returning done in the cycle after ena: start in cycle 0; step k has ISSUE in cycle 2k+1 and done in cycle 2k+2; done=1 in cycle 81.
- abort=1 in any non-IDLE state: go to IDLE next edge; busy=0, no done, dout unchanged, step_ena=0. A late step_done is ignored.
- abort and start together in IDLE: start wins; abort is ignored in IDLE.
- Reset asserted mid-operation: immediate return to reset values; a following start behaves as a fresh operation.

Optional Feature:
Macro: AES_SCHED_TIMEOUT_EN.
- Defined: a 4-bit counter clears on ISSUE and counts WAIT cycles. If it reaches TMO_CYC without step_done:
  - err is set and sticky until the next accepted start or reset;
  - the FSM returns to IDLE, busy=0, no done.
- Undefined: no counter is built, err is tied 0, and WAIT lasts indefinitely.

Test Plan:
- FIPS-197 vector with real step units: din bytes 00112233445566778899aabbccddeeff (byte0=0x00 at [7:0]), round keys from key 000102..0f -> one done pulse, dout bytes 69c4e0d86a7b0430d8cdb78070b4c55a, busy falls with done.
- 1-cycle-latency stub units: start in cycle 0 -> done in cycle 81. Sequence log shows step_sel 3, then (0,1,2,3)x9, then 0,1,3. round_idx walks 0..10; step_sel never equals 2 while round_idx=10.
- start pulsed repeatedly while busy -> ignored. Exactly one done; dout unchanged until the next start in IDLE.
- abort in the WAIT of step 20 -> IDLE next edge, busy=0, no done, dout keeps the previous result. A stub done 2 cycles later is ignored; a following start completes normally.
- rst=0 driven asynchronously mid-ISSUE (between clock edges) -> all outputs at reset values before the next edge.
- With AES_SCHED_TIMEOUT_EN and a stub that never returns done -> after 15 WAIT cycles err=1, busy=0, no done. The next start clears err.
